// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types and sizes.
package aes_pkg;
    localparam int AES_STATE_BYTES = 16;
    typedef logic [AES_STATE_BYTES-1:0][7:0] aes_state_t;
endpackage

// File: rtl/aes_ptr_wrap.sv
// aes_ptr_wrap: pointer register that wraps DEPTH-1 -> 0 for any DEPTH.
module aes_ptr_wrap #(
    parameter int DEPTH = 4,
    parameter int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    always_ff @(posedge clk or posedge resetn)
        if (resetn) ptr <= '0;
        else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
endmodule

// File: rtl/aes_state_fifo.sv
// aes_state_fifo: DEPTH-entry in-order buffer of AES states with sticky
// overflow/underflow flags and same-cycle read/write on a full buffer.
module aes_state_fifo
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_STATE_BYTES,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [NBYTES-1:0][7:0] i,
    input  logic                   rd_en,
    output logic [NBYTES-1:0][7:0] o,
    output logic                   o_valid,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   reg_reseted
);
    localparam int PW = $clog2(DEPTH);
    logic [NBYTES-1:0][7:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic rd_ok, wr_ok;
    logic [CW-1:0] count_nxt;
    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en && !empty;
    // a read on a full buffer frees its slot for the write in the same cycle
    assign wr_ok = wr_en && (!full || rd_en);
    always_comb
        count_nxt = (wr_ok && !rd_ok) ? count + CW'(1) :
                    (rd_ok && !wr_ok) ? count - CW'(1) : count;
    aes_ptr_wrap #(.DEPTH(DEPTH)) u_wp (.clk(clk), .resetn(resetn), .inc(wr_ok), .ptr(wp));
    aes_ptr_wrap #(.DEPTH(DEPTH)) u_rp (.clk(clk), .resetn(resetn), .inc(rd_ok), .ptr(rp));
    always_ff @(posedge clk)
        if (wr_ok) mem[wp] <= i;
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            count       <= '0;
            o           <= '0;
            o_valid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            reg_reseted <= 1'b1;
        end else begin
            count       <= count_nxt;
            o_valid     <= rd_ok;
            if (rd_ok) o <= mem[rp];
            overflow    <= (wr_en && !wr_ok) ? 1'b1 : clr ? 1'b0 : overflow;
            underflow   <= (rd_en && empty) ? 1'b1 : clr ? 1'b0 : underflow;
            reg_reseted <= wr_ok ? 1'b0 : reg_reseted;
        end
endmodule

// File: tb/tb_aes_state_fifo.sv
// tb_aes_state_fifo: table-driven checks on a DEPTH=4 instance plus a
// DEPTH=3 streaming sequence and an asynchronous mid-stream reset.
module tb_aes_state_fifo;
    import aes_pkg::*;
    typedef struct {
        logic wr, rd, clr;
        aes_state_t d, o;
        logic ov;
        logic [2:0] cnt;
        logic full, empty, ovf, unf, rr;
    } vec_t;
    logic clk = 1'b0, resetn = 1'b1, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    aes_state_t din = '0;
    aes_state_t o4, o3;
    logic ov4, full4, empty4, ovf4, unf4, rr4;
    logic ov3, full3, empty3, ovf3, unf3, rr3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;
    int checks = 0, errors = 0;
    vec_t v[20];
    aes_state_t s0, a, b, c, d, e, x;

    aes_state_fifo u4 (.clk(clk), .resetn(resetn), .clr(clr), .wr_en(wr_en), .i(din),
        .rd_en(rd_en), .o(o4), .o_valid(ov4), .full(full4), .empty(empty4), .count(cnt4),
        .overflow(ovf4), .underflow(unf4), .reg_reseted(rr4));
    aes_state_fifo #(.DEPTH(3)) u3 (.clk(clk), .resetn(resetn), .clr(clr), .wr_en(wr_en),
        .i(din), .rd_en(rd_en), .o(o3), .o_valid(ov3), .full(full3), .empty(empty3),
        .count(cnt3), .overflow(ovf3), .underflow(unf3), .reg_reseted(rr3));

    always #5 clk = ~clk;

    function automatic aes_state_t st(input logic [7:0] b8);
        return {16{b8}};
    endfunction

    function automatic vec_t mk(input logic wr, rd, cl, input aes_state_t dd, oo,
                                input logic ov, input logic [2:0] cnt,
                                input logic fu, em, of, uf, rr);
        vec_t r;
        r.wr = wr; r.rd = rd; r.clr = cl; r.d = dd; r.o = oo; r.ov = ov; r.cnt = cnt;
        r.full = fu; r.empty = em; r.ovf = of; r.unf = uf; r.rr = rr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        s0 = 128'h0f0e0d0c0b0a09080706050403020100;
        a = st(8'hA1); b = st(8'hB2); c = st(8'hC3); d = st(8'hD4); e = st(8'hE5); x = st(8'h5A);
        v[0]  = mk(0,0,0,'0, '0,0,0,0,1,0,0,1);
        v[1]  = mk(1,0,0,s0,'0,0,1,0,0,0,0,0);
        v[2]  = mk(0,1,0,'0, s0,1,0,0,1,0,0,0);
        v[3]  = mk(0,0,0,'0, s0,0,0,0,1,0,0,0);
        v[4]  = mk(1,0,0,a, s0,0,1,0,0,0,0,0);
        v[5]  = mk(1,0,0,b, s0,0,2,0,0,0,0,0);
        v[6]  = mk(1,0,0,c, s0,0,3,0,0,0,0,0);
        v[7]  = mk(1,0,0,d, s0,0,4,1,0,0,0,0);
        v[8]  = mk(1,0,0,e, s0,0,4,1,0,1,0,0);
        v[9]  = mk(0,0,1,'0, s0,0,4,1,0,0,0,0);
        v[10] = mk(1,1,0,e, a, 1,4,1,0,0,0,0);
        v[11] = mk(0,1,0,'0, b, 1,3,0,0,0,0,0);
        v[12] = mk(0,1,0,'0, c, 1,2,0,0,0,0,0);
        v[13] = mk(0,1,0,'0, d, 1,1,0,0,0,0,0);
        v[14] = mk(0,1,0,'0, e, 1,0,0,1,0,0,0);
        v[15] = mk(1,1,0,x, e, 0,1,0,0,0,1,0);
        v[16] = mk(0,0,1,'0, e, 0,1,0,0,0,0,0);
        v[17] = mk(0,1,0,'0, x, 1,0,0,1,0,0,0);
        v[18] = mk(0,1,1,'0, x, 0,0,0,1,0,1,0);
        v[19] = mk(0,0,1,'0, x, 0,0,0,1,0,0,0);

        @(posedge clk); #1;
        resetn = 1'b0;
        for (int n = 0; n < 20; n++) begin
            wr_en = v[n].wr; rd_en = v[n].rd; clr = v[n].clr; din = v[n].d;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", n),
                {o4, ov4, cnt4, full4, empty4, ovf4, unf4, rr4},
                {v[n].o, v[n].ov, v[n].cnt, v[n].full, v[n].empty, v[n].ovf, v[n].unf, v[n].rr});
        end

        // DEPTH=3: one write and one read per cycle across several pointer wraps
        pulse_reset();
        for (int k = 0; k <= 10; k++) begin
            wr_en = (k < 10); rd_en = (k > 0); din = st(8'h30 + 8'(k));
            @(posedge clk); #1;
            if (k > 0) chk($sformatf("stream_o%0d", k), {o3, ov3}, {st(8'h30 + 8'(k - 1)), 1'b1});
            chk($sformatf("stream_cnt%0d", k), cnt3, (k < 10) ? 2'd1 : 2'd0);
        end

        // asynchronous reset with three entries held
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; din = st(8'hF1 + 8'(k));
            @(posedge clk); #1;
        end
        rd_en = 1'b1; din = st(8'hF4);
        @(posedge clk); #1;
        chk("midstream", {o4, ov4, cnt4}, {st(8'hF1), 1'b1, 3'd3});
        wr_en = 1'b0; rd_en = 1'b0;
        #3;
        resetn = 1'b1;
        #1;
        chk("async_rst", {empty4, cnt4, o4, rr4, ov4}, {1'b1, 3'd0, 128'd0, 1'b1, 1'b0});
        #2;
        resetn = 1'b0;
        rd_en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rd", {unf4, o4, ov4, cnt4, empty4}, {1'b1, 128'd0, 1'b0, 3'd0, 1'b1});
        rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_state_fifo.md
# aes_state_fifo

Parametrised multi-entry buffer for AES state blocks, generalising the single-slot 16-byte state register that sits between round stages (e.g. MixColumns → AddRoundKey). It holds up to DEPTH states of NBYTES bytes each in arrival order. It adds occupancy reporting, same-cycle read/write on a full buffer, sticky overflow/underflow flags and a software clear. Round stages can run decoupled instead of lock-stepping on a one-deep full flag.

## Interface
- NBYTES, 16: bytes per state word; ≥1.
- DEPTH, 4: number of state entries; ≥2, any integer (not restricted to powers of two).
- CW, $clog2(DEPTH+1): derived count width; not overridden.
- clk  in  1  sole clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-high reset. The name follows the codebase port naming; the polarity is high.
- clr  in  1  synchronous clear of the sticky error flags only.
- wr_en  in  1  write request.
- i  in  [NBYTES-1:0][7:0]  state to write.
- rd_en  in  1  read request.
- o  out  [NBYTES-1:0][7:0]  last state read, registered.
- o_valid  out  1  one-cycle pulse: o updated this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  [CW-1:0]  entries held.
- overflow  out  1  sticky: write dropped.
- underflow  out  1  sticky: read on empty.
- reg_reseted  out  1  high from reset until the first accepted write.

## Operation
- Storage: DEPTH × NBYTES × 8 array, write pointer wp and read pointer rp in 0..DEPTH-1. Each pointer wraps DEPTH-1 → 0 explicitly, with no reliance on power-of-two overflow.
- Read accept: rd_ok = rd_en && !empty. On acceptance, o ← mem[rp] and rp advances.
- Write accept: wr_ok = wr_en && (!full || rd_en). A read on a full buffer frees the slot in the same cycle. On acceptance, mem[wp] ← i and wp advances.
- count next value:
  - +1 when wr_ok && !rd_ok.
  - −1 when rd_ok && !wr_ok.
  - Unchanged otherwise.
- Empty with both wr_en and rd_en: the write is accepted and the read is rejected; there is no bypass. underflow is set.
- Full with wr_en and no rd_en: the write is dropped, contents are unchanged, and overflow is set.
- Sticky error flags:
  - overflow and underflow are set by the events above.
  - They are cleared by clr when no new event occurs in the same cycle; a new event in that cycle wins.
- reg_reseted clears on the first wr_ok after reset.
- o holds its value between reads; rejected reads leave o unchanged.
- Memory contents are not reset. Only the pointers, count, flags and o are reset.

## Timing
- Reset (async assert, sync deassert expected upstream) forces:
  - wp = rp = count = 0.
  - empty = 1, full = 0.
  - o = 0, o_valid = 0.
  - overflow = underflow = 0.
  - reg_reseted = 1.
- Reset mid-operation discards all entries immediately. No partial read completes.
- Write-to-read latency: a state written at edge N can be read by a rd_en sampled at edge N+1. It appears on o after edge N+1.
- Read latency is 1: rd_ok sampled at edge N gives o and o_valid valid after edge N, with o_valid high for exactly that cycle.
- full, empty and count are registered and reflect all accepted operations up to the last edge.
- Sustained throughput is one write and one read per cycle at any occupancy from 1 to DEPTH.

## Structure
- Shared package aes_pkg:
  - localparam AES_STATE_BYTES = 16.
  - typedef logic [AES_STATE_BYTES-1:0][7:0] aes_state_t.
  - The top-level default NBYTES is taken from AES_STATE_BYTES.
- One sub-module, aes_ptr_wrap (parameter DEPTH): a pointer register with increment enable, wrap at DEPTH-1, and async reset. Instantiated twice, once for wp and once for rp.
- Storage, count and flags stay in the top module.

## Test plan
- Reset, then write i = 0x00..0x0F (byte k = k), then read:
  - After the write: reg_reseted 1 → 0 and count = 1.
  - After the read: o = 0x0F0E…00, o_valid pulses once, empty = 1.
- DEPTH = 4: write states A, B, C, D with wr_en held, then write E:
  - full = 1 after D.
  - E is dropped and overflow = 1.
  - Four reads return A, B, C, D in order.
- Full buffer, same-cycle wr_en = rd_en = 1 with E:
  - o = A.
  - count stays 4 and overflow stays 0.
  - The next reads return B, C, D, E.
- Empty buffer, wr_en = rd_en = 1 with X:
  - count = 1, underflow = 1, o unchanged, o_valid = 0.
  - Pulse clr: underflow = 0.
- DEPTH = 3 (non-power-of-two): stream 10 states with a write and a read every cycle after the first write. All 10 come out in order across pointer wrap and count never exceeds 1.
- Assert resetn with count = 3 mid-stream:
  - Without waiting for a clock edge, outputs show empty = 1, count = 0, o = 0, reg_reseted = 1.
  - After reset is released, a read sets underflow = 1.
